// File: rtl/udp_rx_filter_if.sv
// udp_rx_filter_if: AXI4-Stream byte channel (data, valid, ready, last, user).
// The filter takes the slave view on its input and the master view on its output.
interface udp_rx_filter_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/udp_rx_filter.sv
// udp_rx_filter: sits between the MAC rx stream and header_skip.
// Buffers the first HEADER_LEN bytes of every frame, checks ethertype IPv4,
// version/IHL 0x45, protocol UDP and the UDP destination port, then either
// replays the header and passes the payload through, or swallows the frame.
// Optional build macro MAC_FILTER_EN: additionally require the destination
// MAC (bytes 0-5) to be LOCAL_MAC or broadcast.
module udp_rx_filter #(
  parameter int          HEADER_LEN = 42,
  parameter logic [15:0] UDP_PORT   = 16'd26400,
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01
) (
  input  logic            clk,
  input  logic            rst,
  udp_rx_filter_if.slave  s_axis,
  udp_rx_filter_if.master m_axis,
  output logic [31:0]     stat_accepted,
  output logic [31:0]     stat_dropped,
  output logic            drop_pulse
);

  // Byte counter covers 0..HEADER_LEN-1; replay index also needs HEADER_LEN
  // to mark "every header byte has been handed to the output register".
  localparam int               CNT_W    = $clog2(HEADER_LEN);
  localparam int               IDX_W    = $clog2(HEADER_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HEADER_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(HEADER_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HEADER_LEN - 1);

  typedef enum logic [1:0] {
    S_HDR,
    S_REPLAY,
    S_PASS,
    S_DROP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Header store: written while collecting, read one byte at a time on replay.
  logic [7:0]       r_hdr_buf [HEADER_LEN];

  logic [CNT_W-1:0] r_cnt;
  logic             r_match;
  logic             r_last_seen;
  logic             r_last_user;
  logic [IDX_W-1:0] r_rd_idx;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_out_user;
  logic [31:0]      r_stat_acc;
  logic [31:0]      r_stat_drop;
  logic             r_drop_pulse;

  logic             w_hdr_acc;
  logic             w_hdr_last_byte;
  logic             w_field_ok;
  logic             w_mac_ok;
  logic             w_match_final;
  logic             w_out_xfer;
  logic             w_go_replay;
  logic             w_drop_evt;
  logic             w_accept_evt;
  logic             w_rd_en;
  logic [CNT_W-1:0] w_rd_addr;

  assign w_hdr_acc       = (r_state == S_HDR) && s_axis.tvalid && !rst;
  assign w_hdr_last_byte = (r_cnt == LAST_CNT);
  assign w_out_xfer      = r_out_valid && m_axis.tready;
  assign w_match_final   = r_match && w_field_ok && w_mac_ok;

  // Per-byte field check for the byte currently being accepted.
  always_comb begin
    w_field_ok = 1'b1;
    case (r_cnt)
      CNT_W'(12): w_field_ok = (s_axis.tdata == 8'h08);
      CNT_W'(13): w_field_ok = (s_axis.tdata == 8'h00);
      CNT_W'(14): w_field_ok = (s_axis.tdata == 8'h45);
      CNT_W'(23): w_field_ok = (s_axis.tdata == 8'h11);
      CNT_W'(36): w_field_ok = (s_axis.tdata == UDP_PORT[15:8]);
      CNT_W'(37): w_field_ok = (s_axis.tdata == UDP_PORT[7:0]);
      default:    w_field_ok = 1'b1;
    endcase
  end

`ifdef MAC_FILTER_EN
  logic [5:0] w_local_hit;
  logic       w_mac_byte;
  logic       w_local_ok;
  logic       w_bcast_ok;
  logic       r_mac_local;
  logic       r_mac_bcast;

  for (genvar gi = 0; gi < 6; gi++) begin : g_mac_cmp
    assign w_local_hit[gi] = (r_cnt == CNT_W'(gi)) &&
                             (s_axis.tdata == LOCAL_MAC[47-8*gi -: 8]);
  end

  assign w_mac_byte = (r_cnt < CNT_W'(6));
  assign w_local_ok = !w_mac_byte || (|w_local_hit);
  assign w_bcast_ok = !w_mac_byte || (s_axis.tdata == 8'hFF);

  // Track "all dst bytes so far equal LOCAL_MAC" and "all equal FF" separately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mac_local <= 1'b0;
      r_mac_bcast <= 1'b0;
    end else if (w_hdr_acc) begin
      if (r_cnt == '0) begin
        r_mac_local <= w_local_ok;
        r_mac_bcast <= w_bcast_ok;
      end else begin
        r_mac_local <= r_mac_local & w_local_ok;
        r_mac_bcast <= r_mac_bcast & w_bcast_ok;
      end
    end
  end

  assign w_mac_ok = r_mac_local | r_mac_bcast;
`else
  // Destination MAC is ignored in this build; LOCAL_MAC folds to a constant
  // that nothing consumes.
  logic w_unused_local_mac;
  assign w_unused_local_mac = ^LOCAL_MAC;
  assign w_mac_ok           = 1'b1;
`endif

  // Next-state, handshake and output steering.
  always_comb begin
    w_state_next  = r_state;
    w_go_replay   = 1'b0;
    w_drop_evt    = 1'b0;
    w_accept_evt  = 1'b0;
    w_rd_en       = 1'b0;
    w_rd_addr     = '0;
    s_axis.tready = 1'b0;
    m_axis.tdata  = r_out_data;
    m_axis.tvalid = r_out_valid;
    m_axis.tlast  = r_out_last;
    m_axis.tuser  = r_out_user;
    case (r_state)
      S_HDR: begin
        s_axis.tready = !rst;
        if (w_hdr_acc) begin
          if (w_hdr_last_byte) begin
            if (w_match_final) begin
              w_state_next = S_REPLAY;
              w_go_replay  = 1'b1;
              w_rd_en      = 1'b1;
              w_rd_addr    = '0;
            end else begin
              w_drop_evt   = 1'b1;
              w_state_next = s_axis.tlast ? S_HDR : S_DROP;
            end
          end else if (s_axis.tlast) begin
            // Runt: frame ended before the decision point.
            w_drop_evt = 1'b1;
          end
        end
      end
      S_REPLAY: begin
        if (w_out_xfer) begin
          if (r_rd_idx == IDX_END) begin
            w_accept_evt = 1'b1;
            w_state_next = r_last_seen ? S_HDR : S_PASS;
          end else begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_rd_idx[CNT_W-1:0];
          end
        end
      end
      S_PASS: begin
        m_axis.tdata  = s_axis.tdata;
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tlast  = s_axis.tlast;
        m_axis.tuser  = s_axis.tuser;
        s_axis.tready = m_axis.tready && !rst;
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
          w_state_next = S_HDR;
        end
      end
      S_DROP: begin
        s_axis.tready = !rst;
        if (s_axis.tvalid && s_axis.tlast) begin
          w_state_next = S_HDR;
        end
      end
      default: w_state_next = S_HDR;
    endcase
  end

  // Header capture port of the buffer.
  always_ff @(posedge clk) begin
    if (w_hdr_acc) begin
      r_hdr_buf[r_cnt] <= s_axis.tdata;
    end
  end

  // Registered read port doubles as the replay output data register; it only
  // advances on a transfer so data holds steady under backpressure.
  always_ff @(posedge clk) begin
    if (w_rd_en) begin
      r_out_data <= r_hdr_buf[w_rd_addr];
    end
  end

  // State register, header bookkeeping, replay sequencing and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_HDR;
      r_cnt        <= '0;
      r_match      <= 1'b0;
      r_last_seen  <= 1'b0;
      r_last_user  <= 1'b0;
      r_rd_idx     <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_user   <= 1'b0;
      r_stat_acc   <= '0;
      r_stat_drop  <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_hdr_acc) begin
        r_cnt   <= (w_hdr_last_byte || s_axis.tlast) ? '0 : r_cnt + 1'b1;
        r_match <= (r_cnt == '0) ? w_field_ok : (r_match & w_field_ok);
      end

      if (w_go_replay) begin
        r_last_seen <= s_axis.tlast;
        r_last_user <= s_axis.tuser;
        r_rd_idx    <= IDX_W'(1);
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b0;
        r_out_user  <= 1'b0;
      end else if (w_out_xfer) begin
        if (r_rd_idx == IDX_END) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_out_user  <= 1'b0;
        end else begin
          r_rd_idx   <= r_rd_idx + 1'b1;
          r_out_last <= (r_rd_idx == IDX_LAST) && r_last_seen;
          r_out_user <= (r_rd_idx == IDX_LAST) && r_last_seen && r_last_user;
        end
      end

      if (w_accept_evt) begin
        r_stat_acc <= r_stat_acc + 32'd1;
      end
      if (w_drop_evt) begin
        r_stat_drop <= r_stat_drop + 32'd1;
      end
      r_drop_pulse <= w_drop_evt;
    end
  end

  assign stat_accepted = r_stat_acc;
  assign stat_dropped  = r_stat_drop;
  assign drop_pulse    = r_drop_pulse;

endmodule

// File: doc/udp_rx_filter.md
Name: udp_rx_filter

Overview:
- Sits between the MAC's rx_axis stream and header_skip, in the fabric clock domain.
- Buffers the first HEADER_LEN bytes of each received frame and checks the Ethernet, IPv4 and UDP header fields.
- Matching frames are forwarded intact (header replayed, then payload passed through); all other frames are discarded.
- This keeps ARP, ICMP and foreign UDP traffic out of the ITCH parser.

Parameters:
- HEADER_LEN, 42: bytes buffered before the accept decision; must be >= 38; header_skip strips the same count.
- UDP_PORT, 16'd26400: required UDP destination port (frame bytes 36-37, big-endian).
- LOCAL_MAC, 48'h02_00_00_00_00_01: accepted destination MAC; used only when MAC_FILTER_EN is defined.

Ports:
- clk  input  1  fabric clock.
- rst  input  1  synchronous reset, active-high.
- s_axis_tdata  input  8  frame byte from the MAC.
- s_axis_tvalid  input  1  input byte valid.
- s_axis_tready  output  1  input accept.
- s_axis_tlast  input  1  last byte of frame.
- s_axis_tuser  input  1  MAC bad-frame flag, meaningful on tlast.
- m_axis_tdata  output  8  byte to header_skip.
- m_axis_tvalid  output  1  output byte valid.
- m_axis_tready  input  1  downstream accept.
- m_axis_tlast  output  1  last byte of frame.
- m_axis_tuser  output  1  copy of s_axis_tuser on the forwarded last byte.
- stat_accepted  output  32  count of frames forwarded; wraps.
- stat_dropped  output  32  count of frames discarded; wraps.
- drop_pulse  output  1  one-cycle pulse when a frame is classified as dropped.

Behaviour:
- Clocking/reset: single clock; synchronous active-high reset.
- Reset values: state=HDR, byte counter=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, s_axis_tready=0 during rst and 1 in the cycle after, stats=0, drop_pulse=0.
- A byte transfers on tvalid&&tready. Output data/last/user stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- State HDR:
  - s_axis_tready=1, m_axis_tvalid=0.
  - Each accepted byte is written to hdr_buf[cnt]; cnt increments.
  - Field checks are evaluated as bytes arrive and sticky-ANDed into a match flag:
    - bytes 12,13 = 0x08,0x00
    - byte 14 = 0x45
    - byte 23 = 0x11
    - bytes 36,37 = UDP_PORT[15:8], UDP_PORT[7:0]
  - tlast with cnt < HEADER_LEN-1 (runt): drop, return to HDR with cnt=0, stat_dropped+1, drop_pulse; the DROP state is not entered.
  - Byte HEADER_LEN-1 accepted with match=1 -> REPLAY; the frame's "last seen" flag records whether this byte carried tlast (and tuser).
  - Byte HEADER_LEN-1 accepted with match=0 -> DROP, or directly back to HDR if that byte carried tlast. stat_dropped+1 and drop_pulse in the decision cycle.
- State REPLAY:
  - s_axis_tready=0.
  - Outputs hdr_buf[0..HEADER_LEN-1] from a registered output stage; the first byte is valid on the cycle after the decision (latency 1).
  - After the final header byte transfers:
    - if the header ended the frame, that byte carries tlast/tuser; stat_accepted+1; next state HDR.
    - otherwise, stat_accepted+1 and next state PASS.
- State PASS:
  - Combinational pass-through: m_axis_tdata/tvalid/tlast/tuser follow s_axis; s_axis_tready = m_axis_tready.
  - Transfer with tlast -> HDR, cnt=0.
- State DROP:
  - s_axis_tready=1, m_axis_tvalid=0.
  - Consume bytes until tlast -> HDR.
- Back-to-back frames: the byte after tlast belongs to the next frame and is captured as byte 0 in HDR without a gap cycle.
- Stats increment exactly once per frame and wrap from 0xFFFFFFFF to 0.
- A tuser=1 frame that was accepted still counts as accepted; the bad flag is forwarded, not filtered.
- Reset asserted mid-frame: everything returns to reset values. Input bytes arriving after reset are treated as byte 0 of a new frame; recovery relies on the filter checks rejecting the misaligned remainder.

Optional Feature:
- Macro: MAC_FILTER_EN.
- Defined: bytes 0-5 must equal LOCAL_MAC or FF:FF:FF:FF:FF:FF; this check is ANDed into match.
- Undefined: destination MAC is ignored, the LOCAL_MAC parameter is unused, and no comparator logic is built.

Test Plan:
- UDP frame, port 26400, 42-byte header + 10-byte payload, m_axis_tready=1 -> output is the identical 52 bytes; tlast on byte 51; stat_accepted=1; first output one cycle after input byte 41.
- ARP frame (ethertype 0x0806, 60 bytes) followed by a matching frame -> no output for the ARP frame; drop_pulse once; stat_dropped=1; the matching frame is forwarded intact.
- UDP to port 80 -> dropped after byte 41; the remaining bytes are consumed with s_axis_tready=1; stat_dropped=1.
- Runt: 20-byte frame with tlast -> no output; stat_dropped=1; the next frame's byte 0 is captured correctly.
- Random m_axis_tready toggling (50%) across 3 back-to-back matching frames -> byte-exact output, tdata stable while stalled, stat_accepted=3.
- With MAC_FILTER_EN: dst 02:00:00:00:00:02 -> dropped; dst FF:FF:FF:FF:FF:FF -> accepted. Without the macro, both are accepted.
